// File: rtl/inst_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: format codes, common opcodes,
// the FIFO entry layout and a sign-extension fit helper. Feature macro: INST_ENC_RANGE_CHECK_EN.
package inst_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } inst_fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // True when v survives truncation to nbits and sign-extension back to 32 bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
        logic [31:0] shl;
        logic [31:0] sext;
        shl  = v << (32 - nbits);
        sext = 32'($signed(shl) >>> (32 - nbits));
        return sext == v;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-instruction output handshakes of inst_encoder.
// master = program loader / imem writer side, slave = the encoder.
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic        err_sticky;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err, err_sticky
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err, err_sticky
    );
endinterface

// File: rtl/inst_enc_fifo.sv
// Synchronous FIFO for encoded entries; push and pop may occur in the same cycle.
// The read port returns zero while empty so idle outputs stay at their reset value.
module inst_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: the read port is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/inst_encoder.sv
// Packs RV32I fields into instruction words tagged with sequential imem byte addresses.
// Define INST_ENC_RANGE_CHECK_EN to flag immediates that do not fit the chosen format.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    inst_encoder_if.slave bus
);
    logic [31:0] enc_inst;
    logic        fmt_ok;
    logic        range_err;
    logic        enc_err;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [31:0] addr_q;
    logic        sticky_q;
    entry_t      wr_entry;
    entry_t      head;

    always_comb begin
        enc_inst = '0;
        fmt_ok   = 1'b1;
        case (bus.in_fmt)
            FMT_R: enc_inst = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                               bus.in_rd, bus.in_opcode};
            FMT_I: enc_inst = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                               bus.in_rd, bus.in_opcode};
            FMT_S: enc_inst = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                               bus.in_imm[4:0], bus.in_opcode};
            FMT_B: enc_inst = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                               bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
            FMT_U: enc_inst = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
            FMT_J: enc_inst = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                               bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
            default: begin
                enc_inst = '0;
                fmt_ok   = 1'b0;
            end
        endcase
    end

`ifdef INST_ENC_RANGE_CHECK_EN
    // Out-of-range immediates are still encoded (truncated); only the flag reports them.
    always_comb begin
        range_err = 1'b0;
        case (bus.in_fmt)
            FMT_I, FMT_S: range_err = !fits_signed(bus.in_imm, 32'd12);
            FMT_B:        range_err = !fits_signed(bus.in_imm, 32'd13) || bus.in_imm[0];
            FMT_U:        range_err = |bus.in_imm[11:0];
            FMT_J:        range_err = !fits_signed(bus.in_imm, 32'd21) || bus.in_imm[0];
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign enc_err = !fmt_ok || range_err;

    assign bus.in_ready = reset_n && !clear && !full;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = bus.out_valid && bus.out_ready;

    assign wr_entry = '{inst: enc_inst, addr: addr_q, err: enc_err};

    inst_enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= BASE_ADDR;
            sticky_q <= 1'b0;
        end else if (clear) begin
            addr_q   <= BASE_ADDR;
            sticky_q <= 1'b0;
        end else if (push) begin
            addr_q <= addr_q + 32'd4;
            if (enc_err) sticky_q <= 1'b1;
        end
    end

    assign bus.out_valid  = !empty;
    assign bus.out_inst   = head.inst;
    assign bus.out_addr   = head.addr;
    assign bus.out_err    = head.err;
    assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed scoreboard bench for inst_encoder: encodings, FIFO full/backpressure,
// simultaneous push/pop, address wrap, clear and asynchronous reset.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_FFF0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;

    inst_encoder_if bus ();

    inst_encoder #(
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          pops = 0;
    exp_t        sb[$];
    logic [31:0] exp_addr;
    logic        exp_sticky;
    logic [31:0] cur_inst;
    logic        cur_err;

    function automatic logic [31:0] model_enc(input logic [2:0] fmt, input logic [6:0] op,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        logic [31:0] regs;
        regs = (32'(rs1) << 15) | (32'(f3) << 12);
        w = 32'(op);
        case (fmt)
            3'd0: w = w | (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7);
            3'd1: w = w | ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7);
            3'd2: w = w | (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs
                        | ((imm & 32'h1F) << 7);
            3'd3: w = w | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                        | (32'(rs2) << 20) | regs | (((imm >> 1) & 32'hF) << 8)
                        | (((imm >> 11) & 32'h1) << 7);
            3'd4: w = w | (imm & 32'hFFFF_F000) | (32'(rd) << 7);
            3'd5: w = w | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                        | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                        | (32'(rd) << 7);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic logic model_err(input logic [2:0] fmt, input logic [31:0] imm);
        logic e;
        e = (fmt > 3'd5);
`ifdef INST_ENC_RANGE_CHECK_EN
        case (fmt)
            3'd1, 3'd2: e = (imm != {{20{imm[11]}}, imm[11:0]});
            3'd3:       e = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
            3'd4:       e = (imm[11:0] != 12'h0);
            3'd5:       e = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
            default:    e = (fmt > 3'd5);
        endcase
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_f(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        bus.in_fmt    = fmt;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
        cur_inst      = model_enc(fmt, op, rd, rs1, rs2, f3, f7, imm);
        cur_err       = model_err(fmt, imm);
    endtask

    task automatic set_rand();
        set_f(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 3'($urandom), 7'($urandom), $urandom);
    endtask

    // Called at a falling edge; handshakes are evaluated just after it, away from the rising edge.
    task automatic tick(input bit v, input bit r);
        logic acc;
        logic pp;
        exp_t e;
        bus.in_valid  = v;
        bus.out_ready = r;
        #1;
        acc = bus.in_valid && bus.in_ready;
        pp  = bus.out_valid && bus.out_ready;
        if (pp) begin
            pops++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_output observed=%0h expected=none", bus.out_inst);
            end else begin
                e = sb.pop_front();
                chk("out_inst", bus.out_inst, e.inst);
                chk("out_addr", bus.out_addr, e.addr);
                chk("out_err", 32'(bus.out_err), 32'(e.err));
            end
        end
        if (acc) begin
            sb.push_back('{inst: cur_inst, addr: exp_addr, err: cur_err});
            exp_addr = exp_addr + 32'd4;
            if (cur_err) exp_sticky = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 50) begin
            tick(1'b0, 1'b1);
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        #1;
        chk("drained_out_valid", 32'(bus.out_valid), 32'd0);
        chk("err_sticky", 32'(bus.err_sticky), 32'(exp_sticky));
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        chk("clear_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        exp_addr   = BASE;
        exp_sticky = 1'b0;
        #1;
        chk("clear_out_valid", 32'(bus.out_valid), 32'd0);
        chk("clear_sticky", 32'(bus.err_sticky), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_f(3'd0, OP_REG, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        exp_addr   = BASE;
        exp_sticky = 1'b0;

        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        chk("rst_out_addr", bus.out_addr, 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        chk("rst_sticky", 32'(bus.err_sticky), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // addi x1,x0,-1 with one-cycle latency and hold under backpressure
        set_f(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        cur_inst = 32'hFFF0_0093;
        tick(1'b1, 1'b0);
        chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
        chk("addi_inst", bus.out_inst, 32'hFFF0_0093);
        chk("addi_addr", bus.out_addr, BASE);
        tick(1'b0, 1'b0);
        chk("hold_inst", bus.out_inst, 32'hFFF0_0093);
        tick(1'b0, 1'b1);

        // back-to-back encodings, consumer ready
        set_f(3'd3, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        cur_inst = 32'h0020_8463;
        tick(1'b1, 1'b1);
        set_f(3'd5, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        cur_inst = 32'h0010_00EF;
        tick(1'b1, 1'b1);
        set_f(3'd0, OP_REG, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'hDEAD_BEEF);
        tick(1'b1, 1'b1);
        set_f(3'd2, OP_STORE, 5'd0, 5'd2, 5'd9, 3'd2, 7'd0, 32'hFFFF_FFF4);
        tick(1'b1, 1'b1);
        set_f(3'd4, OP_LUI, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        tick(1'b1, 1'b1);
        drain();

        // illegal formats
        set_f(3'd6, OP_IMM, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'h5);
        tick(1'b1, 1'b1);
        set_f(3'd7, OP_IMM, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'h5);
        tick(1'b1, 1'b1);
        drain();
        do_clear();

        // range boundaries
        set_f(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        tick(1'b1, 1'b1);
        set_f(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047);
        tick(1'b1, 1'b1);
        set_f(3'd3, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        tick(1'b1, 1'b1);
        set_f(3'd4, OP_AUIPC, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001);
        tick(1'b1, 1'b1);
        set_f(3'd5, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000);
        tick(1'b1, 1'b1);
        drain();
        do_clear();
        set_f(3'd1, OP_LOAD, 5'd5, 5'd6, 5'd0, 3'd2, 7'd0, 32'd16);
        tick(1'b1, 1'b1);
        drain();

        // fill past capacity with consumer stalled
        do_clear();
        pops = 0;
        for (int i = 0; i < DEPTH; i++) begin
            set_rand();
            tick(1'b1, 1'b0);
        end
        #1;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        set_rand();
        tick(1'b1, 1'b0);
        chk("full_fifth_held", 32'(sb.size()), 32'(DEPTH));
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        bus.in_valid = 1'b0;
        drain();
        chk("full_pop_count", 32'(pops), 32'(DEPTH + 1));

        // steady push/pop at half-full across the address wrap
        do_clear();
        for (int i = 0; i < DEPTH / 2; i++) begin
            set_rand();
            tick(1'b1, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            set_rand();
            tick(1'b1, 1'b1);
            chk("steady_out_valid", 32'(bus.out_valid), 32'd1);
        end
        chk("steady_occupancy", 32'(sb.size()), 32'(DEPTH / 2));
        bus.in_valid = 1'b0;
        drain();

        // asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) begin
            set_rand();
            tick(1'b1, 1'b0);
        end
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("async_rst_sticky", 32'(bus.err_sticky), 32'd0);
        sb.delete();
        exp_addr   = BASE;
        exp_sticky = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        set_f(3'd1, OP_IMM, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd1);
        tick(1'b1, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
